// File: rtl/user_wb_pkg.sv
// Shared types and constants for the user-area Wishbone splitter.
package user_wb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StResp   = 2'd2
  } state_e;

  // Read data returned when the address decodes to no project.
  localparam logic [31:0] DEC_ERR_DATA = 32'hBADA_DD00;
  // Read data returned when the selected project never acks.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_0001;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/user_wb_timer.sv
// Per-transaction watchdog counter plus a saturating count of expiries.
module user_wb_timer
  import user_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       event_i,
  output logic       expired_o,
  output logic [7:0] event_cnt_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  evt_q, evt_d;

  // Next-state for the watchdog and the event counter; clear beats enable.
  always_comb begin
    cnt_d = cnt_q;
    evt_d = evt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (event_i) begin
      evt_d = sat_inc8(evt_q);
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      evt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  assign expired_o   = (cnt_q == 16'(TIMEOUT_CYCLES));
  assign event_cnt_o = evt_q;

endmodule

// File: rtl/user_wb_splitter.sv
// Wishbone 1-to-N splitter: decodes the user-area address, forwards a single classic cycle to
// the selected project and terminates misses and hung slaves locally.
module user_wb_splitter
  import user_wb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 2,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] BASE_MASK      = 32'hFF00_0000,
  parameter int unsigned SEL_LSB        = 20,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic [NUM_SLAVES-1:0]      m_cyc_o,
  output logic [NUM_SLAVES-1:0]      m_stb_o,
  output logic                       m_we_o,
  output logic [3:0]                 m_sel_o,
  output logic [31:0]                m_adr_o,
  output logic [31:0]                m_dat_o,
  input  logic [NUM_SLAVES-1:0]      m_ack_i,
  input  logic [32*NUM_SLAVES-1:0]   m_dat_i,
  output logic                       timeout_o,
  output logic [7:0]                 timeout_cnt_o
);

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] m_cyc_q, m_cyc_d;
  logic                  m_we_q, m_we_d;
  logic [3:0]            m_sel_q, m_sel_d;
  logic [31:0]           m_adr_q, m_adr_d;
  logic [31:0]           m_dat_q, m_dat_d;
  logic [31:0]           dat_q, dat_d;
  logic                  timeout_q, timeout_d;

  logic [1:0]            req_idx;
  logic                  req_hit;
  logic [NUM_SLAVES-1:0] req_oh;
  logic                  ack_hit;
  logic [31:0]           ack_data;
  logic                  tmr_clr, tmr_en, tmr_evt, tmr_expired;

  assign req_idx = wbs_adr_i[SEL_LSB +: 2];
  assign req_hit = ((wbs_adr_i & BASE_MASK) == BASE_ADDR) && ({30'd0, req_idx} < NUM_SLAVES);

  // One-hot target for the incoming request.
  always_comb begin
    req_oh = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_oh[k] = (req_idx == 2'(k));
    end
  end

  // Only the strobed slave's ack counts; strays from other slaves are masked here.
  assign ack_hit = |(m_ack_i & m_cyc_q);

  // Read data from the currently strobed slave.
  always_comb begin
    ack_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (m_cyc_q[k]) begin
        ack_data = m_dat_i[32*k +: 32];
      end
    end
  end

  user_wb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .event_i    (tmr_evt),
    .expired_o  (tmr_expired),
    .event_cnt_o(timeout_cnt_o)
  );

  // Transaction FSM next-state and datapath capture.
  always_comb begin
    state_d   = state_q;
    m_cyc_d   = m_cyc_q;
    m_we_d    = m_we_q;
    m_sel_d   = m_sel_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    dat_d     = dat_q;
    timeout_d = 1'b0;
    tmr_clr   = 1'b1;
    tmr_en    = 1'b0;
    tmr_evt   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          m_we_d  = wbs_we_i;
          m_sel_d = wbs_sel_i;
          m_adr_d = wbs_adr_i;
          m_dat_d = wbs_dat_i;
          if (req_hit) begin
            m_cyc_d = req_oh;
            state_d = StActive;
          end else begin
            dat_d   = DEC_ERR_DATA;
            state_d = StResp;
          end
        end
      end
      StActive: begin
        tmr_clr = 1'b0;
        // A master that has left gets no ack, even if the slave answers this cycle.
        if (!wbs_cyc_i) begin
          m_cyc_d = '0;
          state_d = StIdle;
        end else if (ack_hit) begin
          m_cyc_d = '0;
          dat_d   = ack_data;
          state_d = StResp;
        end else if (tmr_expired) begin
          m_cyc_d   = '0;
          dat_d     = TIMEOUT_DATA;
          timeout_d = 1'b1;
          tmr_evt   = 1'b1;
          state_d   = StResp;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      m_cyc_q   <= '0;
      m_we_q    <= 1'b0;
      m_sel_q   <= '0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      dat_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_cyc_q   <= m_cyc_d;
      m_we_q    <= m_we_d;
      m_sel_q   <= m_sel_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      dat_q     <= dat_d;
      timeout_q <= timeout_d;
    end
  end

  assign wbs_ack_o = (state_q == StResp);
  assign wbs_dat_o = dat_q;
  assign m_cyc_o   = m_cyc_q;
  assign m_stb_o   = m_cyc_q;
  assign m_we_o    = m_we_q;
  assign m_sel_o   = m_sel_q;
  assign m_adr_o   = m_adr_q;
  assign m_dat_o   = m_dat_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_user_wb_splitter.sv
// Randomized bench for user_wb_splitter with a transaction-level reference model.
module tb_user_wb_splitter;

  localparam int          NS  = 2;
  localparam int          TO  = 8;
  localparam logic [31:0] DEC = 32'hBADA_DD00;
  localparam logic [31:0] TOD = 32'hDEAD_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack_o;
  logic [31:0] rdat;
  logic [1:0]  mcyc, mstb;
  logic        mwe;
  logic [3:0]  msel;
  logic [31:0] madr, mdat;
  logic [1:0]  sack = '0;
  logic [63:0] sdat = '0;
  logic        to_o;
  logic [7:0]  to_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Slave behaviour knobs.
  int          s_dly[NS] = '{100, 100};
  int          s_age[NS] = '{0, 0};
  bit          stray_en = 1'b0, stray_force = 1'b0, fixed_en = 1'b1;
  logic [31:0] fixed_dat[NS] = '{32'h0, 32'h0};

  // Model state and expected outputs.
  int          mdl_tgt = -1;
  int          mdl_wait = 0;
  bit          mdl_resp = 1'b0;
  logic        e_ack = 1'b0, e_to = 1'b0, e_we = 1'b0;
  logic [1:0]  e_stb = '0;
  logic [31:0] e_dat = '0, e_adr = '0, e_mdat = '0;
  logic [3:0]  e_sel = '0;
  logic [7:0]  e_tocnt = '0;

  user_wb_splitter #(
    .NUM_SLAVES    (NS),
    .BASE_ADDR     (32'h3000_0000),
    .BASE_MASK     (32'hFF00_0000),
    .SEL_LSB       (20),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_ack_o    (ack_o),
    .wbs_dat_o    (rdat),
    .m_cyc_o      (mcyc),
    .m_stb_o      (mstb),
    .m_we_o       (mwe),
    .m_sel_o      (msel),
    .m_adr_o      (madr),
    .m_dat_o      (mdat),
    .m_ack_i      (sack),
    .m_dat_i      (sdat),
    .timeout_o    (to_o),
    .timeout_cnt_o(to_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slaves: ack after a programmed number of strobe cycles; unselected ones may ack stray.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NS; k++) begin
      if (mstb[k]) begin
        sack[k] = (s_age[k] == s_dly[k]);
        s_age[k]++;
      end else begin
        s_age[k] = 0;
        sack[k]  = stray_force || (stray_en && ($urandom_range(0, 3) == 0));
      end
      sdat[32*k +: 32] = fixed_en ? fixed_dat[k] : $urandom();
    end
  end

  // Reference model: one outstanding request, tracked as target slave and cycles waited.
  always @(posedge clk) begin
    if (rst) begin
      mdl_tgt = -1; mdl_wait = 0; mdl_resp = 1'b0;
      e_ack = 1'b0; e_to = 1'b0; e_stb = '0; e_dat = '0; e_tocnt = '0;
      e_we = 1'b0; e_sel = '0; e_adr = '0; e_mdat = '0;
    end else begin
      e_to = 1'b0;
      if (mdl_resp) begin
        mdl_resp = 1'b0;
      end else if (mdl_tgt >= 0) begin
        if (!cyc) begin
          mdl_tgt = -1;
        end else if (sack[mdl_tgt]) begin
          e_dat    = sdat[32*mdl_tgt +: 32];
          mdl_tgt  = -1;
          mdl_resp = 1'b1;
        end else if (mdl_wait == TO) begin
          e_dat    = TOD;
          e_to     = 1'b1;
          if (e_tocnt != 8'd255) e_tocnt = e_tocnt + 8'd1;
          mdl_tgt  = -1;
          mdl_resp = 1'b1;
        end else begin
          mdl_wait++;
        end
      end else if (cyc && stb) begin
        e_we = we; e_sel = sel; e_adr = adr; e_mdat = wdat;
        if (adr[31:24] == 8'h30 && int'(adr[21:20]) < NS) begin
          mdl_tgt  = int'(adr[21:20]);
          mdl_wait = 0;
        end else begin
          e_dat    = DEC;
          mdl_resp = 1'b1;
        end
      end
      e_ack = mdl_resp;
      e_stb = (mdl_tgt >= 0) ? 2'(1 << mdl_tgt) : 2'b00;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 128'(ack_o), 128'(e_ack));
      check("rdata", 128'(rdat), 128'(e_dat));
      check("m_cyc", 128'(mcyc), 128'(e_stb));
      check("m_stb", 128'(mstb), 128'(e_stb));
      check("m_req", 128'({mwe, msel, madr, mdat}), 128'({e_we, e_sel, e_adr, e_mdat}));
      check("timeout", 128'(to_o), 128'(e_to));
      check("timeout_cnt", 128'(to_cnt), 128'(e_tocnt));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One master transaction; called and returns at #1 after a rising edge.
  task automatic do_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                        input logic [3:0] t_sel, input int abort_after, output int n,
                        output bit acked, output logic [1:0] seen, output bit to_seen);
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_dat; sel = t_sel;
    n = 0; acked = 1'b0; seen = '0; to_seen = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      seen = seen | mstb;
      if (ack_o) begin
        acked   = 1'b1;
        to_seen = to_o;
        break;
      end
      if (abort_after != 0 && n == abort_after) break;
      if (n >= 60) begin
        n_checks++;
        n_errors++;
        $display("FAIL txn_hang: no ack after %0d cycles, required within 60", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    int          n;
    bit          acked, tos;
    logic [1:0]  seen;
    logic [31:0] r;
    int          ab;

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1;
    @(negedge clk);
    check("rst_ack", 128'(ack_o), 128'(0));
    check("rst_stb", 128'(mstb), 128'(0));
    check("rst_tocnt", 128'(to_cnt), 128'(0));
    check("rst_rdat", 128'(rdat), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Read slave0, ack 3 cycles after strobe.
    fixed_dat[0] = 32'h1234_5678; fixed_dat[1] = 32'hCAFE_0002;
    s_dly[0] = 3; s_dly[1] = 100;
    do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, n, acked, seen, tos);
    check("t1_acked", 128'(acked), 128'(1));
    check("t1_stb", 128'(seen), 128'(2'b01));
    check("t1_lat", 128'(n), 128'(6));
    check("t1_dat", 128'(rdat), 128'(32'h1234_5678));
    check("t1_to", 128'(tos), 128'(0));

    // Write slave1.
    s_dly[0] = 100; s_dly[1] = 1;
    do_txn(1'b1, 32'h3010_0000, 32'hA5A5_A5A5, 4'hF, 0, n, acked, seen, tos);
    check("t2_stb", 128'(seen), 128'(2'b10));
    check("t2_mdat", 128'(mdat), 128'(32'hA5A5_A5A5));
    check("t2_lat", 128'(n), 128'(4));
    check("t2_rdat", 128'(rdat), 128'(32'hCAFE_0002));
    @(negedge clk);
    check("t2_single_ack", 128'(ack_o), 128'(0));
    idle(1);

    // Decode misses: wrong base and out-of-range index.
    do_txn(1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, n, acked, seen, tos);
    check("t3_stb", 128'(seen), 128'(0));
    check("t3_lat", 128'(n), 128'(2));
    check("t3_dat", 128'(rdat), 128'(32'hBADA_DD00));
    do_txn(1'b0, 32'h3020_0000, 32'h0, 4'hF, 0, n, acked, seen, tos);
    check("t3b_stb", 128'(seen), 128'(0));
    check("t3b_lat", 128'(n), 128'(2));

    // Slave1 never acks.
    s_dly[1] = 100;
    do_txn(1'b0, 32'h3010_0000, 32'h0, 4'hF, 0, n, acked, seen, tos);
    check("t4_stb", 128'(seen), 128'(2'b10));
    check("t4_lat", 128'(n), 128'(11));
    check("t4_dat", 128'(rdat), 128'(32'hDEAD_0001));
    check("t4_to", 128'(tos), 128'(1));
    check("t4_tocnt", 128'(to_cnt), 128'(1));

    // Ack lands on the same cycle the timer expires: ack wins.
    s_dly[1] = 8;
    do_txn(1'b0, 32'h3010_0000, 32'h0, 4'hF, 0, n, acked, seen, tos);
    check("t5_lat", 128'(n), 128'(11));
    check("t5_dat", 128'(rdat), 128'(32'hCAFE_0002));
    check("t5_to", 128'(tos), 128'(0));
    check("t5_tocnt", 128'(to_cnt), 128'(1));

    // Master abort two cycles into the slave access.
    s_dly[1] = 100;
    do_txn(1'b0, 32'h3010_0000, 32'h0, 4'hF, 3, n, acked, seen, tos);
    check("t6_noack", 128'(acked), 128'(0));
    @(negedge clk);
    check("t6_hold", 128'(mstb), 128'(2'b10));
    @(negedge clk);
    check("t6_drop", 128'(mstb), 128'(0));
    check("t6_ack", 128'(ack_o), 128'(0));
    idle(2);

    // Stray slave0 acks while slave1 is selected.
    stray_force = 1'b1; s_dly[1] = 2;
    do_txn(1'b0, 32'h3010_0000, 32'h0, 4'hF, 0, n, acked, seen, tos);
    check("t7_lat", 128'(n), 128'(5));
    check("t7_dat", 128'(rdat), 128'(32'hCAFE_0002));
    stray_force = 1'b0;
    idle(1);

    // Reset in the middle of an access.
    s_dly[1] = 100;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3010_0000; sel = 4'hF;
    repeat (3) @(negedge clk);
    check("t8_active", 128'(mstb), 128'(2'b10));
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t8_stb", 128'(mstb), 128'(0));
    check("t8_ack", 128'(ack_o), 128'(0));
    check("t8_tocnt", 128'(to_cnt), 128'(0));
    check("t8_adr", 128'(madr), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    fixed_dat[0] = 32'h5555_AAAA; s_dly[0] = 2;
    do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, n, acked, seen, tos);
    check("t8_post_lat", 128'(n), 128'(5));
    check("t8_post_dat", 128'(rdat), 128'(32'h5555_AAAA));

    // Random traffic.
    fixed_en = 1'b0; stray_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      case ($urandom_range(0, 3))
        0: begin r[31:24] = 8'h30; r[21:20] = 2'd0; end
        1: begin r[31:24] = 8'h30; r[21:20] = 2'd1; end
        2: begin r[31:24] = 8'h30; r[21:20] = 2'($urandom_range(2, 3)); end
        default: if (r[31:24] == 8'h30) r[31:24] = 8'h31;
      endcase
      for (int k = 0; k < NS; k++) begin
        s_dly[k] = ($urandom_range(0, 5) == 0) ? 100 : $urandom_range(0, 10);
      end
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 10) : 0;
      do_txn(1'($urandom_range(0, 1)), r, $urandom(), 4'($urandom_range(0, 15)), ab,
             n, acked, seen, tos);
      if (ab != 0) idle(2);
      idle($urandom_range(0, 2));
    end

    // Timeout counter saturation.
    stray_en = 1'b0; s_dly[0] = 100; s_dly[1] = 100;
    for (int i = 0; i < 260; i++) begin
      do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, n, acked, seen, tos);
    end
    check("sat_tocnt", 128'(to_cnt), 128'(255));
    check("sat_dat", 128'(rdat), 128'(32'hDEAD_0001));

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
